// File: rtl/ste_report_pkg.sv
// Shared types for the STE report collector: FSM states, default sizing, record layout.
// The record struct matches the default sizing; non-default builds derive their own layout.
package ste_report_pkg;

  localparam int DEF_NUM_REPORTS = 4;
  localparam int DEF_OFFSET_W    = 32;
  localparam int DEF_DEPTH       = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_OFFSET_W-1:0]    offset;
    logic [DEF_NUM_REPORTS-1:0] bits;
  } record_t;

endpackage

// File: rtl/ste_report_if.sv
// Symbol/report inputs from the STE array and the ready/valid record stream out of the collector.
// master is the array + consumer side, slave is the collector.
interface ste_report_if
  import ste_report_pkg::*;
#(
  parameter int NUM_REPORTS = DEF_NUM_REPORTS,
  parameter int OFFSET_W    = DEF_OFFSET_W
);

  logic                   symbolValid;
  logic [NUM_REPORTS-1:0] reportVector;
  logic                   endOfStream;
  logic                   reportValid;
  logic                   reportReady;
  logic [OFFSET_W-1:0]    reportOffset;
  logic [NUM_REPORTS-1:0] reportBits;

  modport master (
    output symbolValid, reportVector, endOfStream, reportReady,
    input  reportValid, reportOffset, reportBits
  );

  modport slave (
    input  symbolValid, reportVector, endOfStream, reportReady,
    output reportValid, reportOffset, reportBits
  );

endinterface

// File: rtl/ste_report_fifo.sv
// Generic synchronous FIFO, DEPTH entries (power of two), simultaneous push/pop.
// Latency: a push is visible at the head one cycle later, no bypass.
// Backpressure: push ignored when full unless a pop happens the same cycle.
module ste_report_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             wrEn;
  logic             rdEn;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wrEn  = push && (!full || pop);
  assign rdEn  = pop && !empty;
  // Head is masked while empty so the output reads zero after reset.
  assign popData = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (rdEn) rdPtr <= rdPtr + 1'b1;
      count <= count + {{AW{1'b0}}, wrEn} - {{AW{1'b0}}, rdEn};
    end
  end

  always_ff @(posedge clock) begin
    if (wrEn) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/ste_report_collector.sv
// Tags non-empty STE report vectors with their symbol offset and queues them; optional REPORT_DROP_COUNT_EN adds dropCount.
// Latency: record valid one cycle after the reporting symbol; done one cycle after the final pop.
// Backpressure: reportReady low holds the head; pushes into a full FIFO without a pop are dropped.
module ste_report_collector
  import ste_report_pkg::*;
#(
  parameter int NUM_REPORTS = DEF_NUM_REPORTS,
  parameter int OFFSET_W    = DEF_OFFSET_W,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic        clock,
  input  logic        resetN,
  ste_report_if.slave rpt,
  output logic        overflow,
  output logic        done
`ifdef REPORT_DROP_COUNT_EN
  ,
  output logic [15:0] dropCount
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [OFFSET_W-1:0]    offset;
    logic [NUM_REPORTS-1:0] bits;
  } rec_t;

  state_t              state;
  state_t              nextState;
  logic [OFFSET_W-1:0] offset;
  rec_t                pushRec;
  rec_t                headRec;
  logic                running;
  logic                pushReq;
  logic                pop;
  logic                accept;
  logic                drop;
  logic                full;
  logic                empty;
  logic [AW:0]         count;
  logic                nextEmpty;

  assign running = (state == RUN);
  assign pushReq = running && rpt.symbolValid && (|rpt.reportVector);
  assign pop     = rpt.reportValid && rpt.reportReady;
  assign accept  = pushReq && (!full || pop);
  assign drop    = pushReq && full && !pop;
  // FIFO will hold nothing after this edge: lets done rise right after the last pop.
  assign nextEmpty = !accept && (empty || (count == (AW+1)'(1) && pop));

  assign pushRec.offset = offset;
  assign pushRec.bits   = rpt.reportVector;

  ste_report_fifo #(
    .WIDTH ($bits(rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .resetN   (resetN),
    .push     (pushReq),
    .pushData (pushRec),
    .pop      (pop),
    .popData  (headRec),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign rpt.reportValid  = !empty;
  assign rpt.reportOffset = headRec.offset;
  assign rpt.reportBits   = headRec.bits;
  assign done             = (state == DONE);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= RUN;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      RUN:     if (rpt.endOfStream) nextState = nextEmpty ? DONE : DRAIN;
      DRAIN:   if (nextEmpty)       nextState = DONE;
      default: nextState = state;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      offset   <= '0;
      overflow <= 1'b0;
    end else begin
      if (running && rpt.symbolValid) offset <= offset + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef REPORT_DROP_COUNT_EN
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)                           dropCount <= '0;
    else if (drop && dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
  end
`endif

endmodule

// File: doc/ste_report_collector.md
# ste_report_collector

Downstream stage of the STE match array: samples the array's per-reporting-STE report lines once per consumed 16-bit symbol, tags each non-empty report with the symbol offset, and buffers it in a FIFO drained over a ready/valid interface. Tracks end-of-stream and signals completion once every buffered report has been delivered. Replaces per-symbol `$display` reporting with a back-pressured record stream.

## Interface
- `NUM_REPORTS`, 4 — number of reporting STEs (width of report vector)
- `OFFSET_W`, 32 — symbol offset counter width
- `DEPTH`, 16 — FIFO entries, power of two, ≥2

- `clock`  in  1  sole clock, rising edge
- `resetN`  in  1  reset, asynchronous assert, active-low
- `symbolValid`  in  1  array consumed one 16-bit symbol this cycle
- `reportVector`  in  NUM_REPORTS  `activateChildren` of each reporting STE, qualified by `symbolValid`
- `endOfStream`  in  1  pulse: no further symbols; may coincide with the last `symbolValid`
- `reportValid`  out  1  output record available
- `reportReady`  in  1  consumer accepts record
- `reportOffset`  out  OFFSET_W  symbol offset of record
- `reportBits`  out  NUM_REPORTS  report vector of record
- `overflow`  out  1  sticky: ≥1 report dropped since reset
- `done`  out  1  stream ended and FIFO drained
- `dropCount`  out  16  saturating drop count (only with `REPORT_DROP_COUNT_EN`)

## Operation
- Offset counter: 0 after reset; increments by 1 on every `symbolValid`; wraps modulo 2^OFFSET_W. Record uses the pre-increment value (first symbol = offset 0).
- Push condition: `symbolValid && |reportVector` in state RUN. Push writes {offset, reportVector}.
- Pop condition: `reportValid && reportReady`.
- Full and push without pop: record dropped, `overflow` set, FIFO unchanged. Full with simultaneous pop: push accepted (no drop).
- Empty with push: record visible next cycle, no combinational bypass.
- FSM states RUN, DRAIN, DONE:
  - RUN → DRAIN on `endOfStream`; a push in the same cycle is still taken.
  - DRAIN: `symbolValid` ignored (no push, no offset increment); → DONE when FIFO empty.
  - DONE: `done`=1; all inputs except `resetN` ignored; held until reset.
- `endOfStream` in DRAIN/DONE ignored.
- Reset mid-operation: FIFO emptied, offset 0, state RUN, flags cleared; in-flight records lost.

## Timing
- Reset values: `reportValid`=0, `reportOffset`=0, `reportBits`=0, `overflow`=0, `done`=0, `dropCount`=0.
- Push-to-`reportValid` latency: 1 cycle.
- Outputs registered/FIFO-head driven; `reportOffset`/`reportBits` stable while `reportValid`=1 and `reportReady`=0.
- `reportValid` never drops without a pop.
- `done` rises the cycle after the final pop (or the cycle after `endOfStream` if FIFO already empty).
- Sustained throughput: one push and one pop per cycle.

## Configuration
- `REPORT_DROP_COUNT_EN` defined: `dropCount` port present; increments by 1 per dropped record, saturates at 16'hFFFF, reset to 0.
- Undefined: `dropCount` port absent, no counter logic; `overflow` is the only drop indication.

## Structure
- Package `ste_report_pkg`: FSM state typedef (RUN, DRAIN, DONE), default parameter constants, record struct {offset, bits}.
- One sub-module `ste_report_fifo`: synchronous FIFO, DEPTH entries, full/empty, simultaneous push/pop; collector holds counter, FSM, drop logic.

## Test plan
- Symbols with reports at offsets 2 and 5 (vectors 4'b0001, 4'b0110), `reportReady`=1 → two records {2,0001}, {5,0110}, each 1 cycle after its push.
- `reportReady`=0, 18 consecutive reporting symbols, DEPTH=16 → 16 records offsets 0–15 retained, `overflow`=1, `dropCount`=2; draining yields offsets 0–15 in order.
- FIFO full, push and pop same cycle → no drop, `overflow` stays 0, new record appears last.
- `endOfStream` on last reporting symbol with 3 queued, `reportReady` toggled → all 4 delivered, `done`=1 the cycle after final pop; later `symbolValid` produces nothing.
- `resetN` asserted with 5 queued in DRAIN → all outputs at reset values immediately; next symbol reports at offset 0.
